// File: rtl/ay_psg_bus_slave.sv
// Chip-side responder for the AY-3-8910 bus: synchronizes BDIR/BC2/BC1/DA, filters glue
// transients, decodes latch/write/read and owns the 16-entry masked register file.
module ay_psg_bus_slave #(
    parameter int         FILT_CYCLES = 3,
    parameter logic [3:0] ADDR_HI     = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bdir,
    input  logic       bc2,
    input  logic       bc1,
    input  logic [7:0] da_in,
    output logic [7:0] da_out,
    output logic       da_oe,
    input  logic [3:0] gen_raddr,
    output logic [7:0] gen_rdata,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic       env_restart
);

    localparam logic [2:0] FILT = FILT_CYCLES[2:0];

    typedef enum logic [2:0] {
        IDLE,
        LATCH_HOLD,
        WRITE_HOLD,
        READ_HOLD,
        WAIT_INACT
    } state_t;

    typedef enum logic [1:0] {
        CMD_INACT,
        CMD_LATCH,
        CMD_WRITE,
        CMD_READ
    } cmd_t;

    logic [2:0] ctl_s1, ctl_s2;
    logic [7:0] da_s1, da_s2;
    logic [2:0] code_q;
    logic [2:0] cnt;
    logic       qualified;
    cmd_t       cmd;
    cmd_t       held_cmd;
    logic       start;

    state_t     state, state_next;
    logic       do_latch, do_write, do_read, do_release;

    logic [7:0] regs [16];
    logic [3:0] addr;
    logic       sel;

    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
            default:                 reg_mask = 8'hFF;
        endcase
    endfunction

    // Synchronizers and the stability counter; code_q is the code the counter refers to.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_s1 <= 3'b000;
            ctl_s2 <= 3'b000;
            da_s1  <= 8'h00;
            da_s2  <= 8'h00;
            code_q <= 3'b000;
            cnt    <= 3'd0;
        end else begin
            ctl_s1 <= {bdir, bc2, bc1};
            ctl_s2 <= ctl_s1;
            da_s1  <= da_in;
            da_s2  <= da_s1;
            code_q <= ctl_s2;
            if (ctl_s2 == code_q) begin
                if (cnt != 3'd7) cnt <= cnt + 3'd1;
            end else begin
                cnt <= 3'd1;
            end
        end
    end

    always_comb begin
        case (code_q)
            3'b001, 3'b100, 3'b111: cmd = CMD_LATCH;
            3'b110:                 cmd = CMD_WRITE;
            3'b011:                 cmd = CMD_READ;
            default:                cmd = CMD_INACT;
        endcase
    end

    assign qualified = (cnt >= FILT);

    // Command a hold state is waiting out; a different active command restarts action.
    always_comb begin
        case (state)
            LATCH_HOLD: held_cmd = CMD_LATCH;
            WRITE_HOLD: held_cmd = CMD_WRITE;
            READ_HOLD:  held_cmd = CMD_READ;
            WAIT_INACT: held_cmd = CMD_READ;
            default:    held_cmd = CMD_INACT;
        endcase
    end

    assign start = qualified && (cmd != CMD_INACT) &&
                   ((state == IDLE) || (cmd != held_cmd));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            case (cmd)
                CMD_LATCH: state_next = LATCH_HOLD;
                CMD_WRITE: state_next = WRITE_HOLD;
                CMD_READ:  state_next = sel ? READ_HOLD : WAIT_INACT;
                default:   state_next = IDLE;
            endcase
        end else if (qualified && (cmd == CMD_INACT)) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        do_latch   = start && (cmd == CMD_LATCH);
        do_write   = start && (cmd == CMD_WRITE);
        do_read    = start && (cmd == CMD_READ);
        do_release = qualified && (cmd == CMD_INACT) && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
            addr        <= 4'd0;
            sel         <= 1'b1;
            da_out      <= 8'h00;
            da_oe       <= 1'b0;
            wr_stb      <= 1'b0;
            wr_addr     <= 4'd0;
            env_restart <= 1'b0;
        end else begin
            wr_stb      <= 1'b0;
            env_restart <= 1'b0;
            if (do_latch) begin
                if (da_s2[7:4] == ADDR_HI) begin
                    addr <= da_s2[3:0];
                    sel  <= 1'b1;
                end else begin
                    sel  <= 1'b0;
                end
            end
            if (do_write && sel) begin
                regs[addr]  <= da_s2 & reg_mask(addr);
                wr_stb      <= 1'b1;
                wr_addr     <= addr;
                env_restart <= (addr == 4'd13);
            end
            if (do_release || start) da_oe <= 1'b0;
            if (do_read && sel) begin
                da_out <= regs[addr] & reg_mask(addr);
                da_oe  <= 1'b1;
            end
        end
    end

    assign gen_rdata = regs[gen_raddr] & reg_mask(gen_raddr);

endmodule

// File: tb/tb_ay_psg_bus_slave.sv
// Directed bench for ay_psg_bus_slave: bus cycles held across the filter window, with
// pulse counting over each phase and register-file readback through the generator port.
module tb_ay_psg_bus_slave;

    localparam logic [2:0] C_INACT = 3'b000;
    localparam logic [2:0] C_LATCH = 3'b001;
    localparam logic [2:0] C_WRITE = 3'b110;
    localparam logic [2:0] C_READ  = 3'b011;

    logic       clk = 1'b0;
    logic       reset;
    logic       bdir, bc2, bc1;
    logic [7:0] da_in;
    logic [7:0] da_out;
    logic       da_oe;
    logic [3:0] gen_raddr;
    logic [7:0] gen_rdata;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic       env_restart;

    int checks   = 0;
    int errors   = 0;
    int stb_cnt  = 0;
    int env_cnt  = 0;
    int env_long = 0;
    int oe_cnt   = 0;
    logic env_prev = 1'b0;
    logic seen;

    ay_psg_bus_slave dut (
        .clk         (clk),
        .reset       (reset),
        .bdir        (bdir),
        .bc2         (bc2),
        .bc1         (bc1),
        .da_in       (da_in),
        .da_out      (da_out),
        .da_oe       (da_oe),
        .gen_raddr   (gen_raddr),
        .gen_rdata   (gen_rdata),
        .wr_stb      (wr_stb),
        .wr_addr     (wr_addr),
        .env_restart (env_restart)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        stb_cnt  = 0;
        env_cnt  = 0;
        env_long = 0;
        oe_cnt   = 0;
    endtask

    // Drive a code/data pair at a falling edge and hold it n cycles, sampling outputs.
    task automatic bus(input logic [2:0] code, input logic [7:0] d, input int n);
        {bdir, bc2, bc1} = code;
        da_in = d;
        repeat (n) begin
            @(negedge clk);
            if (wr_stb) stb_cnt++;
            if (env_restart) env_cnt++;
            if (env_restart && env_prev) env_long++;
            if (da_oe) oe_cnt++;
            env_prev = env_restart;
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        gen_raddr = idx;
        #1;
        check(tag, {24'h0, gen_rdata}, {24'h0, exp});
    endtask

    initial begin
        reset = 1'b1;
        {bdir, bc2, bc1} = C_INACT;
        da_in = 8'h00;
        gen_raddr = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_da_out", {24'h0, da_out}, 32'h00);
        check("rst_da_oe", {31'h0, da_oe}, 32'h0);
        check("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        check("rst_env", {31'h0, env_restart}, 32'h0);
        check_reg("rst_reg7", 4'd7, 8'h00);
        reset = 1'b0;
        bus(C_INACT, 8'h00, 4);

        // Plain latch + write to a full-width register.
        clear_counts();
        bus(C_LATCH, 8'h07, 8);
        bus(C_INACT, 8'h00, 8);
        bus(C_WRITE, 8'hF8, 8);
        bus(C_INACT, 8'h00, 8);
        check("w7_stb_cnt", stb_cnt, 1);
        check("w7_wr_addr", {28'h0, wr_addr}, 32'h7);
        check_reg("w7_reg7", 4'd7, 8'hF8);
        check_reg("w7_reg0", 4'd0, 8'h00);
        check("w7_env_cnt", env_cnt, 0);

        // Masked register R1, then read back over the bus.
        clear_counts();
        bus(C_LATCH, 8'h01, 8);
        bus(C_INACT, 8'h00, 8);
        bus(C_WRITE, 8'hFF, 8);
        bus(C_INACT, 8'h00, 8);
        check_reg("w1_reg1", 4'd1, 8'h0F);
        check("w1_oe_before", oe_cnt, 0);
        bus(C_READ, 8'h00, 8);
        check("r1_da_out", {24'h0, da_out}, 32'h0F);
        bus(C_INACT, 8'h00, 8);
        check("r1_oe_cycles", oe_cnt, 8);
        check("r1_oe_low", {31'h0, da_oe}, 32'h0);
        check("r1_da_out_hold", {24'h0, da_out}, 32'h0F);
        check("r1_stb_cnt", stb_cnt, 1);

        // R13 written twice with the same value: two single-cycle restarts.
        clear_counts();
        bus(C_LATCH, 8'h0D, 8);
        bus(C_INACT, 8'h00, 8);
        bus(C_WRITE, 8'h0E, 8);
        bus(C_INACT, 8'h00, 8);
        bus(C_WRITE, 8'h0E, 8);
        bus(C_INACT, 8'h00, 8);
        check("r13_env_cnt", env_cnt, 2);
        check("r13_env_width", env_long, 0);
        check("r13_stb_cnt", stb_cnt, 2);
        check("r13_wr_addr", {28'h0, wr_addr}, 32'hD);
        check_reg("r13_value", 4'd13, 8'h0E);

        // Latch with wrong high nibble deselects the chip.
        clear_counts();
        bus(C_LATCH, 8'h15, 8);
        bus(C_INACT, 8'h00, 8);
        bus(C_WRITE, 8'h55, 8);
        bus(C_INACT, 8'h00, 8);
        bus(C_READ, 8'h00, 8);
        bus(C_INACT, 8'h00, 8);
        check("desel_stb_cnt", stb_cnt, 0);
        check("desel_oe_cnt", oe_cnt, 0);
        check_reg("desel_reg13", 4'd13, 8'h0E);
        check_reg("desel_reg5", 4'd5, 8'h00);
        clear_counts();
        bus(C_LATCH, 8'h05, 8);
        bus(C_INACT, 8'h00, 8);
        bus(C_WRITE, 8'h55, 8);
        bus(C_INACT, 8'h00, 8);
        check("resel_stb_cnt", stb_cnt, 1);
        check("resel_wr_addr", {28'h0, wr_addr}, 32'h5);
        check_reg("resel_reg5", 4'd5, 8'h05);

        // Short WRITE glitch is filtered out.
        clear_counts();
        bus(C_WRITE, 8'hAA, 2);
        bus(C_INACT, 8'h00, 8);
        check("glitch_stb_cnt", stb_cnt, 0);
        check_reg("glitch_reg5", 4'd5, 8'h05);

        // One-cycle 001 between WRITE and INACT must not re-latch to R3.
        clear_counts();
        bus(C_WRITE, 8'h3A, 8);
        bus(C_LATCH, 8'h03, 1);
        bus(C_INACT, 8'h00, 8);
        bus(C_WRITE, 8'h07, 8);
        bus(C_INACT, 8'h00, 8);
        check("trans_stb_cnt", stb_cnt, 2);
        check("trans_wr_addr", {28'h0, wr_addr}, 32'h5);
        check_reg("trans_reg5", 4'd5, 8'h07);
        check_reg("trans_reg3", 4'd3, 8'h00);

        // Reset two cycles into an accepted read.
        bus(C_LATCH, 8'h01, 8);
        bus(C_INACT, 8'h00, 8);
        {bdir, bc2, bc1} = C_READ;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = da_oe;
        end
        check("rr_oe_rise", {31'h0, seen}, 32'h1);
        check("rr_da_out", {24'h0, da_out}, 32'h0F);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        {bdir, bc2, bc1} = C_INACT;
        @(negedge clk);
        check("rr_oe_drop", {31'h0, da_oe}, 32'h0);
        check("rr_da_out_clr", {24'h0, da_out}, 32'h00);
        check_reg("rr_reg1", 4'd1, 8'h00);
        check_reg("rr_reg5", 4'd5, 8'h00);
        check_reg("rr_reg7", 4'd7, 8'h00);
        check_reg("rr_reg13", 4'd13, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_counts();
        bus(C_INACT, 8'h00, 8);
        bus(C_READ, 8'h00, 8);
        check("post_rd_oe", {31'h0, da_oe}, 32'h1);
        check("post_rd_data", {24'h0, da_out}, 32'h00);
        bus(C_INACT, 8'h00, 8);
        check("post_rd_oe_low", {31'h0, da_oe}, 32'h0);
        check("post_stb_cnt", stb_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
